data_mem_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle data memory: a byte-addressed, word-organised data RAM

---
 rtl/data_mem_ctrl_pkg.sv | 16 +
 rtl/data_mem_ctrl_lane_align.sv | 28 ++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 tb/tb_data_mem_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: access size codes, FSM states and the shared alignment helper for the data memory controller.
package data_mem_ctrl_pkg;
    localparam int WORD_SIZE = 32;
    localparam logic [1:0] DMEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] DMEM_SZ_HALF = 2'b01;
    localparam logic [1:0] DMEM_SZ_WORD = 2'b10;
    localparam logic [1:0] DMEM_SZ_RSVD = 2'b11;
    typedef enum logic [1:0] {
        DMEM_ST_IDLE = 2'b00,
        DMEM_ST_WAIT = 2'b01,
        DMEM_ST_RESP = 2'b10
    } state_t;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == DMEM_SZ_HALF && lane[0]) || (size == DMEM_SZ_WORD && lane != 2'b00);
    endfunction
endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// dmem_lane_align: merges store data into the addressed lanes and extracts/extends load data.
module dmem_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [WORD_SIZE-1:0] old_word,
    input  logic [1:0]           size,
    input  logic [1:0]           lane,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 zext,
    output logic [WORD_SIZE-1:0] store_word,
    output logic [WORD_SIZE-1:0] load_data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = old_word[{lane, 3'b000} +: 8];
        h = lane[1] ? old_word[31:16] : old_word[15:0];
        store_word = old_word;
        if (size == DMEM_SZ_BYTE)
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (size == DMEM_SZ_HALF)
            store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        else if (size == DMEM_SZ_WORD)
            store_word = wdata;
        load_data = size == DMEM_SZ_BYTE ? {{24{~zext & b[7]}}, b} :
                    size == DMEM_SZ_HALF ? {{16{~zext & h[15]}}, h} : old_word;
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed word RAM behind valid/ready request/response with programmable latency.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of truncating the address.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic r_we, r_zext, err, access, unused_addr;
    logic [1:0] r_size, r_lane;
    logic [IDX_W-1:0] r_idx;
    logic [WORD_SIZE-1:0] r_wdata, store_word, load_data;
    logic [WORD_SIZE-1:0] mem [DEPTH];

    // Address bits above the word index wrap and are deliberately ignored.
    assign unused_addr = ^(req_addr >> (IDX_W + 2));

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = r_size == DMEM_SZ_RSVD || misaligned(r_size, r_lane);
`else
    assign err = r_size == DMEM_SZ_RSVD;
`endif

    dmem_lane_align u_align (
        .old_word   (mem[r_idx]),
        .size       (r_size),
        .lane       (r_lane),
        .wdata      (r_wdata),
        .zext       (r_zext),
        .store_word (store_word),
        .load_data  (load_data)
    );

    always_ff @(posedge clk)
        state <= rst ? DMEM_ST_IDLE : state_next;

    always_comb begin
        state_next = state;
        access     = 1'b0;
        req_ready  = state == DMEM_ST_IDLE;
        resp_valid = state == DMEM_ST_RESP;
        case (state)
            DMEM_ST_IDLE: state_next = req_valid ? DMEM_ST_WAIT : DMEM_ST_IDLE;
            DMEM_ST_WAIT: begin
                access     = cnt == '0;
                state_next = access ? DMEM_ST_RESP : DMEM_ST_WAIT;
            end
            DMEM_ST_RESP: state_next = resp_ready ? DMEM_ST_IDLE : DMEM_ST_RESP;
            default:      state_next = DMEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (req_ready && req_valid) begin
            cnt     <= CNT_W'(LATENCY - 1);
            r_we    <= req_we;
            r_size  <= req_size;
            r_zext  <= req_unsigned;
            r_lane  <= req_addr[1:0];
            r_idx   <= req_addr[IDX_W+1:2];
            r_wdata <= req_wdata;
        end else if (state == DMEM_ST_WAIT) begin
            if (!access)
                cnt <= cnt - 1'b1;
            else begin
                resp_rdata <= (err || r_we) ? '0 : load_data;
                resp_err   <= err;
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && access && r_we && !err)
            mem[r_idx] <= store_word;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized and directed checks against a byte-level reference model of the data memory.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        resp_valid, resp_ready = 1, resp_err;
    logic [31:0] resp_rdata;

    data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, acc = 0, seen_lat = 0;
    bit busy = 0, started = 0, seen = 0;
    logic [31:0] exp_rdata = 0, last_rdata = 0;
    logic        exp_err = 0, last_err = 0;
    logic [7:0]  mb [BYTES];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, want, cyc);
        end
    endtask

    // Reference: a flat byte array; requests are just sequences of bytes at a (possibly aligned-down) address.
    task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        int base = int'(a & (BYTES - 1));
        er = sz == 2'd3;
`ifdef DMEM_ALIGN_CHECK_EN
        er = er || (base % n != 0);
`endif
        base = base - base % n;
        rd = 0;
        if (!er) begin
            for (int i = 0; i < n; i++)
                if (we) mb[base + i] = wd[8*i +: 8];
                else rd |= 32'(mb[base + i]) << (8 * i);
            if (!we && !uns && n < 4 && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8 * n);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && started) begin
            if (busy) begin
                chk("req_ready_busy", 32'(req_ready), 0);
                chk("resp_valid_timing", 32'(resp_valid), 32'((cyc - acc) >= LAT));
                if (resp_valid && (cyc - acc) >= LAT) begin
                    chk("resp_rdata", resp_rdata, exp_rdata);
                    chk("resp_err", 32'(resp_err), 32'(exp_err));
                    if (!seen) begin
                        seen = 1;
                        seen_lat = cyc - acc;
                    end
                    last_rdata = resp_rdata;
                    last_err = resp_err;
                end
            end else begin
                chk("req_ready_idle", 32'(req_ready), 1);
                chk("resp_valid_idle", 32'(resp_valid), 0);
            end
        end
    end

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                          input logic [31:0] wd, input int h);
        logic [31:0] rd;
        logic er;
        model(we, sz, uns, a, wd, rd, er);
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        acc = cyc; busy = 1; seen = 0; exp_rdata = rd; exp_err = er;
        req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_unsigned = $urandom_range(0, 1);
        resp_ready = h == 0;
        repeat (LAT + h) @(posedge clk);
        #1 resp_ready = 1;
        req_valid = 0;
        @(posedge clk); #1;
        busy = 0;
    endtask

    task automatic lchk(input string name, input logic [31:0] rd, input logic er);
        chk({name, "_dut_rd"}, last_rdata, rd);
        chk({name, "_dut_err"}, 32'(last_err), 32'(er));
        chk({name, "_model_rd"}, exp_rdata, rd);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #4 chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", 32'(resp_err), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        started = 1;
        for (int w = 0; w < 16; w++) do_req(1, 2'd2, 0, 32'(w * 4), $urandom, 0);

        do_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        lchk("t1_store", 32'h0, 0);
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        lchk("t1_load", 32'hDEADBEEF, 0);
        chk("t1_latency", 32'(seen_lat), LAT);
        do_req(1, 2'd0, 0, 32'h11, 32'h5A, 0);
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        lchk("t2_word", 32'hDEAD5AEF, 0);
        do_req(0, 2'd0, 0, 32'h13, 0, 0);
        lchk("t2_byte_s", 32'hFFFFFFDE, 0);
        do_req(0, 2'd0, 1, 32'h13, 0, 0);
        lchk("t2_byte_u", 32'h000000DE, 0);
        do_req(0, 2'd1, 0, 32'h12, 0, 0);
        lchk("t3_half_s", 32'hFFFFDEAD, 0);
        do_req(1, 2'd3, 0, 32'h10, 32'h12345678, 0);
        lchk("t3_rsvd", 32'h0, 1);
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        lchk("t3_unchanged", 32'hDEAD5AEF, 0);
        do_req(0, 2'd2, 0, 32'h11, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        lchk("t4_misaligned", 32'h0, 1);
`else
        lchk("t4_misaligned", 32'hDEAD5AEF, 0);
`endif
        do_req(0, 2'd2, 0, 32'h10, 0, 5);
        lchk("t5_hold", 32'hDEAD5AEF, 0);

        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        acc = cyc; busy = 1; req_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; busy = 0;
        #4 chk("t6_rst_valid", 32'(resp_valid), 0);
        chk("t6_rst_ready", 32'(req_ready), 1);
        chk("t6_rst_rdata", resp_rdata, 0);
        @(posedge clk); #1;
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        lchk("t6_no_write", 32'hDEAD5AEF, 0);
        do_req(0, 2'd2, 0, 32'(BYTES + 'h10), 0, 0);
        lchk("t6_alias_load", 32'hDEAD5AEF, 0);
        do_req(1, 2'd2, 0, 32'(BYTES + 'h10), 32'hCAFEF00D, 0);
        do_req(0, 2'd2, 0, 32'h10, 0, 0);
        lchk("t6_alias_store", 32'hCAFEF00D, 0);

        for (int t = 0; t < 200; t++)
            do_req($urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1),
                   ($urandom & ~32'(BYTES - 1)) | 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
